fixed_normalizer: RTL



---
 rtl/fixedfloat_pkg.sv | 16 +
 rtl/fixed_normalizer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fixedfloat_pkg.sv
// Shared constants and state encoding for the fixed-to-float converter stages.
// Used by fixed_normalizer and by the downstream packing stage.
// Contents: IEEE-754 single field widths, exponent bias, normalizer FSM states.
package fixedfloat_pkg;

  localparam int FLT_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fixed_normalizer.sv
// Purpose: turns a signed fixed-point operand into sign / biased exponent / 23-bit mantissa.
// Latency: zero operand valid after the accept edge; nonzero after sh+1 edges (one left shift per cycle, max 32).
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE, so no accept overlaps a result.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_ready         operand handshake; in_value (two's complement), in_pos (fractional bits)
//   out_valid/out_ready       result handshake
//   out_sign/out_exp/out_mant sign, biased exponent, mantissa without hidden bit (truncated)
//   out_zero                  operand was zero
module fixed_normalizer
  import fixedfloat_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int POS_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_value,
  input  logic [POS_W-1:0]  in_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero
);

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   sh_q, sh_d;

  logic               out_sign_q, out_sign_d;
  logic [EXP_W-1:0]   out_exp_q, out_exp_d;
  logic [MANT_W-1:0]  out_mant_q, out_mant_d;
  logic               out_zero_q, out_zero_d;

  logic [WIDTH-1:0]   in_mag;

  // Most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign in_mag = in_value[WIDTH-1] ? (~in_value + 1'b1) : in_value;

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    pos_d      = pos_q;
    sh_d       = sh_q;
    out_sign_d = out_sign_q;
    out_exp_d  = out_exp_q;
    out_mant_d = out_mant_q;
    out_zero_d = out_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_value[WIDTH-1];
          mag_d  = in_mag;
          pos_d  = in_pos;
          sh_d   = '0;
          if (in_mag == '0) begin
            // Zero skips normalization entirely; result is ready right after the accept edge.
            state_d    = DONE;
            out_sign_d = 1'b0;
            out_exp_d  = '0;
            out_mant_d = '0;
            out_zero_d = 1'b1;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (mag_q[WIDTH-1]) begin
          state_d    = DONE;
          out_sign_d = sign_q;
          // Exponent is formed 9 bits wide and truncated; range 96..158 never wraps.
          out_exp_d  = EXP_W'(9'(FLT_BIAS + WIDTH - 1) - 9'(pos_q) - 9'(sh_q));
          // Bits below the mantissa are dropped: truncation toward zero, no rounding.
          out_mant_d = mag_q[WIDTH-2 -: MANT_W];
          out_zero_d = 1'b0;
        end else begin
          mag_d = mag_q << 1;
          sh_d  = sh_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      pos_q      <= '0;
      sh_q       <= '0;
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
      out_mant_q <= '0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      pos_q      <= pos_d;
      sh_q       <= sh_d;
      out_sign_q <= out_sign_d;
      out_exp_q  <= out_exp_d;
      out_mant_q <= out_mant_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_mant  = out_mant_q;
  assign out_zero  = out_zero_q;

endmodule
